if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline. Owns the program counter and fetches one instruction at a time from a variable-latency instruction memory over a request/response handshake. It drives `pc_plus4_if`/`instrucao_if` straight into the IF/ID pipeline register. When no instruction is ready it emits a NOP bubble, and it handles stall and branch redirect from downstream.

---
 rtl/if_stage_pkg.sv | 13 +
 rtl/if_stage.sv | 98 +++++++++
 tb/tb_if_stage.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
package if_stage_pkg;

    typedef enum logic [1:0] {
        BUSCA   = 2'd0,
        ESPERA  = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, fetches over a req/rsp handshake and
// presents one instruction (or a NOP bubble) to the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        desvio,
    input  logic [31:0] desvio_alvo,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_plus4_if,
    output logic [31:0] instrucao_if
);

    estado_t     estado, estado_n;
    logic [31:0] pc, pc_n;
    logic [31:0] buffer, buffer_n;
    logic        descarta, descarta_n;
    logic [31:0] alvo;

    assign alvo = {desvio_alvo[31:2], 2'b00};

    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= BUSCA;
            pc       <= RESET_PC;
            buffer   <= NOP;
            descarta <= 1'b0;
        end else begin
            estado   <= estado_n;
            pc       <= pc_n;
            buffer   <= buffer_n;
            descarta <= descarta_n;
        end
    end

    // Next state; descarta marks an in-flight response that belongs to a stale PC.
    always_comb begin
        estado_n   = estado;
        pc_n       = pc;
        buffer_n   = buffer;
        descarta_n = descarta;
        unique case (estado)
            BUSCA: begin
                if (desvio) pc_n = alvo;
                if (imem_ready) begin
                    estado_n   = ESPERA;
                    descarta_n = desvio;
                end
            end
            ESPERA: begin
                if (imem_rvalid) begin
                    descarta_n = 1'b0;
                    if (desvio) pc_n = alvo;
                    if (descarta || desvio) begin
                        estado_n = BUSCA;
                    end else begin
                        buffer_n = imem_rdata;
                        estado_n = ENTREGA;
                    end
                end else if (desvio) begin
                    pc_n       = alvo;
                    descarta_n = 1'b1;
                end
            end
            ENTREGA: begin
                if (desvio) begin
                    pc_n     = alvo;
                    estado_n = BUSCA;
                end else if (!stall) begin
                    pc_n     = pc + 32'd4;
                    estado_n = BUSCA;
                end
            end
            default: estado_n = BUSCA;
        endcase
    end

    // Outputs decode directly from the current state.
    always_comb begin
        imem_req     = (estado == BUSCA) && !reset;
        imem_addr    = pc;
        instrucao_if = NOP;
        pc_plus4_if  = 32'h0;
        if (estado == ENTREGA) begin
            instrucao_if = buffer;
            pc_plus4_if  = pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed timing scenarios followed by randomized traffic
// against an architectural PC model and a variable-latency memory model.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clock = 1'b0;
    logic        reset, stall, desvio;
    logic [31:0] desvio_alvo;
    logic        imem_ready, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_req, hi_req;
    logic [31:0] imem_addr, pc_plus4_if, instrucao_if;
    logic [31:0] hi_addr, hi_pc4, hi_instr;

    if_stage dut (
        .clock(clock), .reset(reset), .stall(stall), .desvio(desvio),
        .desvio_alvo(desvio_alvo), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_plus4_if(pc_plus4_if), .instrucao_if(instrucao_if)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
        .clock(clock), .reset(reset), .stall(stall), .desvio(desvio),
        .desvio_alvo(desvio_alvo), .imem_req(hi_req), .imem_addr(hi_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_plus4_if(hi_pc4), .instrucao_if(hi_instr)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // requested inputs for the next cycle
    logic        t_reset = 1'b1, t_stall = 1'b0, t_desvio = 1'b0;
    logic [31:0] t_alvo  = 32'h0;

    // memory model configuration and state
    int          ready_pct = 100, spur_pct = 0, lat_min = 1, lat_max = 1;
    logic        pending = 1'b0;
    logic [31:0] paddr   = 32'h0;
    int          lat_cnt = 0;

    // architectural reference
    logic        model_ok = 1'b0;
    logic [31:0] model_pc = 32'h0;
    int          idle = 0, max_idle = 0;
    logic        rand_phase = 1'b0;

    // outputs sampled mid-cycle
    logic        obs_req, obs_hi_req;
    logic [31:0] obs_addr, obs_instr, obs_pc4, obs_hi_addr, obs_hi_pc4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return (a * 32'h0001_0003) | 32'h1;
    endfunction

    task automatic cycle();
        logic real_rv;
        @(negedge clock);
        reset       = t_reset;
        stall       = t_stall;
        desvio      = t_desvio;
        desvio_alvo = t_alvo;
        imem_ready  = ($urandom_range(99) < ready_pct);
        real_rv     = pending && (lat_cnt == 0);
        if (real_rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(paddr);
        end else if (!pending && ($urandom_range(99) < spur_pct)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom | 32'h1;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        obs_req     = imem_req;
        obs_addr    = imem_addr;
        obs_instr   = instrucao_if;
        obs_pc4     = pc_plus4_if;
        obs_hi_req  = hi_req;
        obs_hi_addr = hi_addr;
        obs_hi_pc4  = hi_pc4;
        if (reset) check("rst_req", obs_req, 1'b0);
        if (model_ok) begin
            if (obs_req) check("req_addr", obs_addr, model_pc);
            if (obs_instr != NOP) begin
                check("instr", obs_instr, mem_word(model_pc));
                check("pc4", obs_pc4, model_pc + 32'd4);
            end else begin
                check("bubble_pc4", obs_pc4, 32'h0);
            end
        end
        @(posedge clock);
        // reference PC: reset, then redirect, then consumption
        if (reset) begin
            model_pc = 32'h0;
            model_ok = 1'b1;
        end else if (desvio) begin
            model_pc = desvio_alvo & ~32'h3;
        end else if (obs_instr != NOP && !stall) begin
            model_pc = model_pc + 32'd4;
        end
        if (obs_instr != NOP || reset) idle = 0;
        else idle++;
        if (rand_phase && idle > max_idle) max_idle = idle;
        // memory: one response per accepted request after its latency
        if (reset) begin
            pending = 1'b0;
        end else begin
            if (real_rv) pending = 1'b0;
            else if (pending) lat_cnt--;
            if (obs_req && imem_ready) begin
                check("one_outstanding", 32'(pending), 32'h0);
                pending = 1'b1;
                paddr   = obs_addr;
                lat_cnt = $urandom_range(lat_max, lat_min) - 1;
            end
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; desvio = 1'b0; desvio_alvo = 32'h0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        repeat (2) cycle();
        t_reset = 1'b0;

        cycle();                                     // c1
        check("c1_req", obs_req, 1'b1);
        check("c1_addr", obs_addr, 32'h0);
        check("c1_instr", obs_instr, NOP);
        repeat (2) cycle();                          // c3
        check("c3_instr", obs_instr, 32'h2008_0005);
        check("c3_pc4", obs_pc4, 32'h4);
        check("wrap_pc4", obs_hi_pc4, 32'h0);
        cycle();                                     // c4
        check("c4_addr", obs_addr, 32'h4);
        check("wrap_req", obs_hi_req, 1'b1);
        check("wrap_addr", obs_hi_addr, 32'h0);
        cycle();                                     // c5
        t_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin            // c6..c9
            cycle();
            check("stall_instr", obs_instr, mem_word(32'h4));
            check("stall_pc4", obs_pc4, 32'h8);
        end
        t_stall = 1'b0;
        cycle();                                     // c10
        lat_min = 3; lat_max = 3;
        cycle();                                     // c11
        check("post_stall_req", obs_req, 1'b1);
        check("post_stall_addr", obs_addr, 32'h8);
        t_desvio = 1'b1; t_alvo = 32'h0000_0043;
        cycle();                                     // c12
        t_desvio = 1'b0;
        cycle();                                     // c13
        check("espera_drop_a", obs_instr, NOP);
        cycle();                                     // c14
        check("espera_drop_b", obs_instr, NOP);
        lat_min = 1; lat_max = 1;
        t_desvio = 1'b1; t_alvo = 32'h0000_0100;
        cycle();                                     // c15
        check("redir_req", obs_req, 1'b1);
        check("redir_addr", obs_addr, 32'h40);
        t_desvio = 1'b0;
        cycle();                                     // c16
        check("busca_drop", obs_instr, NOP);
        cycle();                                     // c17
        check("busca_redir_addr", obs_addr, 32'h100);
        check("busca_redir_instr", obs_instr, NOP);
        repeat (2) cycle();                          // c19
        check("target_instr", obs_instr, mem_word(32'h100));
        check("target_pc4", obs_pc4, 32'h104);
        lat_min = 3; lat_max = 3;
        repeat (2) cycle();                          // c21
        t_reset = 1'b1;
        cycle();                                     // c22
        t_reset = 1'b0; lat_min = 1; lat_max = 1;
        cycle();                                     // c23
        check("rst_espera_req", obs_req, 1'b1);
        check("rst_espera_addr", obs_addr, 32'h0);
        check("rst_espera_instr", obs_instr, NOP);
        cycle();                                     // c24
        check("rst_abort_instr", obs_instr, NOP);
        cycle();                                     // c25
        check("rst_refetch_instr", obs_instr, 32'h2008_0005);

        ready_pct = 60; spur_pct = 10; lat_min = 1; lat_max = 4;
        rand_phase = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            t_reset  = ($urandom_range(199) == 0);
            t_stall  = ($urandom_range(99) < 30);
            t_desvio = ($urandom_range(99) < 5);
            t_alvo   = ($urandom_range(1) == 1) ? 32'($urandom_range(255))
                                                : (32'hFFFF_FF00 | 32'($urandom_range(255)));
            cycle();
        end
        check("liveness", 32'(max_idle > 200), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
